program_loader: RTL

//   Writer side of the 3-bit program store consumed by instruction fetch.

---
 rtl/program_loader_if.sv | 32 +++
 rtl/program_loader.sv | 116 +++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader_if : program word stream in, program store view out
// Rev 1.0
// ----------------------------------------------------------------------------
interface program_loader_if #(
   parameter int WORD_W = 3,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4
);
   logic                      load_start;
   logic                      in_valid;
   logic [WORD_W-1:0]         in_data;
   logic                      in_last;
   logic                      in_ready;
   logic [DEPTH*WORD_W-1:0]   prog_flat;
   logic [PTR_W:0]            prog_len;
   logic                      loaded;
   logic                      halt_req;
   logic [1:0]                err_code;

   modport master (
      output load_start, in_valid, in_data, in_last,
      input  in_ready, prog_flat, prog_len, loaded, halt_req, err_code
   );

   modport slave (
      input  load_start, in_valid, in_data, in_last,
      output in_ready, prog_flat, prog_len, loaded, halt_req, err_code
   );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader : writes a streamed program into the fetch store, holds halt
// Rev 1.0
// ----------------------------------------------------------------------------
module program_loader #(
   parameter int WORD_W = 3,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   program_loader_if.slave    ld_if
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [PTR_W:0] c_full      = (PTR_W+1)'(DEPTH);
   localparam logic [1:0]     c_err_none  = 2'b00;
   localparam logic [1:0]     c_err_ovf   = 2'b01;
   localparam logic [1:0]     c_err_odd   = 2'b10;

   state_t                    state_q, state_d;
   logic [DEPTH*WORD_W-1:0]   flat_q, flat_d;
   logic [PTR_W:0]            ptr_q, ptr_d;
   logic [1:0]                err_q, err_d;
   logic                      loaded_q, loaded_d;
   logic                      halt_q, halt_d;
   logic                      w_xfer;

   assign ld_if.in_ready  = (state_q == ST_LOAD);
   assign w_xfer          = ld_if.in_valid & ld_if.in_ready;

   assign ld_if.prog_flat = flat_q;
   assign ld_if.prog_len  = ptr_q;
   assign ld_if.loaded    = loaded_q;
   assign ld_if.halt_req  = halt_q;
   assign ld_if.err_code  = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         flat_q   <= '0;
         ptr_q    <= '0;
         err_q    <= c_err_none;
         loaded_q <= 1'b0;
         halt_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         flat_q   <= flat_d;
         ptr_q    <= ptr_d;
         err_q    <= err_d;
         loaded_q <= loaded_d;
         halt_q   <= halt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      flat_d   = flat_q;
      ptr_d    = ptr_q;
      err_d    = err_q;
      loaded_d = loaded_q;
      halt_d   = halt_q;

      // A restart wins over any word presented in the same cycle.
      if (ld_if.load_start) begin
         state_d  = ST_LOAD;
         flat_d   = '0;
         ptr_d    = '0;
         err_d    = c_err_none;
         loaded_d = 1'b0;
         halt_d   = 1'b1;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (w_xfer) begin
                  if (ptr_q != c_full) begin
                     for (int i = 0; i < DEPTH; i++) begin
                        if (ptr_q == (PTR_W+1)'(i)) begin
                           flat_d[i*WORD_W +: WORD_W] = ld_if.in_data;
                        end
                     end
                     ptr_d = ptr_q + (PTR_W+1)'(1);
                     // Opcode/operand pairs: the final length must be even.
                     if (ld_if.in_last) begin
                        if (ptr_q[0]) begin
                           state_d  = ST_DONE;
                           loaded_d = 1'b1;
                           halt_d   = 1'b0;
                        end else begin
                           state_d  = ST_ERR;
                           err_d    = c_err_odd;
                        end
                     end
                  end else begin
                     state_d = ST_ERR;
                     err_d   = c_err_ovf;
                  end
               end
            end
            ST_IDLE: ;
            ST_DONE: ;
            ST_ERR:  ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
